data_memory_stage: RTL
======================

// Module: data_memory_stage
// PURPOSE
//   Data-memory stage; sits directly downstream of the memory-access stage.
//   Consumes its instruction, address, write-data and write-enable outputs.
//   Performs word loads/stores on an internal 20-bit RAM with a configurable
//   wait-state latency, and stalls upstream while an access is in flight.
//   Drives the registered MEM/WB pipeline register seen by writeback.
// PARAMETERS
//   ADDR_BITS  8      RAM index width; depth = 2**ADDR_BITS words of 20 bits
//   LATENCY    2      wait cycles per memory op, 0..15
//   OP_LOAD    4'h2   value of instruction[19:16] that marks a load
// PORTS
//   clock            in   1   single clock, rising edge
//   reset            in   1   asynchronous, active-high
//   valid_in         in   1   upstream presents a valid instruction this cycle
//   instruction      in   20  propagated instruction
//   address          in   20  effective address / ALU result
//   writeData        in   20  store data
//   writeEnable      in   1   store request
//   stall            out  1   combinational; upstream must hold and not advance
//   valid_out        out  1   MEM/WB register holds a completed instruction
//   instruction_out  out  20  registered instruction
//   result_out       out  20  load data, else address passed through
//   is_load_out      out  1   result_out is load data
// BEHAVIOUR
//   - mem_op = valid_in & (writeEnable | instruction[19:16]==OP_LOAD).
//   - writeEnable has priority: a store with a load opcode is a store; is_load_out=0.
//   - RAM index = address[ADDR_BITS-1:0]; upper address bits ignored, no fault.
//   - FSM states: IDLE, BUSY. A 4-bit counter cnt tracks wait cycles.
//   - IDLE, valid_in & !mem_op: completes at next edge; stall=0.
//   - IDLE, mem_op, LATENCY==0: completes at next edge; stall=0.
//   - IDLE, mem_op, LATENCY>0: stall=1 this cycle.
//     - At the edge, capture instruction/address/writeData/type into hold regs.
//     - Set cnt<=LATENCY-1 and go to BUSY.
//   - BUSY: inputs ignored; the captured copy is used.
//     - stall = (cnt!=0); cnt decrements each edge while cnt!=0.
//     - cnt==0: the op completes at this edge, state<=IDLE, stall=0 so upstream advances.
//   - Mem op occupancy: LATENCY+1 cycles; stall high for exactly LATENCY cycles.
//   - Completion edge:
//     - valid_out<=1 and instruction_out<=instr.
//     - Store: RAM[idx]<=writeData; result_out<=address.
//     - Load: result_out<=RAM[idx], synchronous read of the pre-edge contents.
//     - Other: result_out<=address.
//   - Edge with no completion: valid_out<=0; instruction_out, result_out, is_load_out hold.
//   - Back-to-back ops: a new op may be accepted in the IDLE cycle right after completion.
//     - Load after store to the same index returns the stored value, since the store committed earlier.
//   - Stores commit only at the completion edge.
//     - Reset mid-BUSY discards the pending store; RAM is unchanged.
//   - Reset, async: state=IDLE, cnt=0, valid_out=0, instruction_out=0,
//     result_out=0, is_load_out=0, stall=0. RAM contents are not reset.
// CONFIGURATION
//   DMEM_STATS_EN defined:
//     - Adds outputs load_count[15:0] and store_count[15:0].
//     - Each increments on a load/store completion edge, saturates at 16'hFFFF, and resets to 0.
//   DMEM_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//   1. Reset asserted mid-cycle -> all outputs 0 immediately, stall=0.
//   2. LATENCY=2: store addr=0x00005 data=0xABCDE.
//      -> stall high 2 cycles; valid_out=1 on 3rd edge with result_out=0x00005.
//      -> Then a load from 0x00005 returns result_out=0xABCDE, is_load_out=1.
//   3. Non-mem instr 0x1F00A, addr=0x00042 -> valid_out next edge, result_out=0x00042, stall never high.
//   4. Store and load to addr 0x10103 and 0x00103 -> same word (ADDR_BITS=8 wraps); load reads the stored data.
//   5. Store to 0x07 issued, reset pulsed in BUSY, then load 0x07 -> returns the prior RAM value, not the store data.
//   6. LATENCY=0: 4 back-to-back loads -> stall stays 0; valid_out high 4 consecutive cycles.
//      -> With DMEM_STATS_EN, load_count=4.

Source files
------------

// File: rtl/data_memory_stage.sv
// Data-memory stage: 20-bit word RAM with wait states, feeding the MEM/WB register.
// Define DMEM_STATS_EN to add saturating load/store completion counters.
module data_memory_stage #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2,
    parameter logic [3:0]  OP_LOAD   = 4'h2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [19:0] instruction,
    input  logic [19:0] address,
    input  logic [19:0] writeData,
    input  logic        writeEnable,
    output logic        stall,
    output logic        valid_out,
    output logic [19:0] instruction_out,
    output logic [19:0] result_out,
    output logic        is_load_out
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count
`endif
);

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam bit          HAS_WAIT = (LATENCY != 0);
    localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;

    logic [19:0] h_instr_q;
    logic [19:0] h_addr_q;
    logic [19:0] h_wdata_q;
    logic        h_store_q;
    logic        h_load_q;

    logic        valid_q;
    logic [19:0] instr_out_q;
    logic [19:0] result_q;
    logic        is_load_q;

    logic [19:0] mem [DEPTH];

    logic                 in_load;
    logic                 mem_op;
    logic                 busy;
    logic                 complete;
    logic                 capture;
    logic [19:0]          op_instr;
    logic [19:0]          op_addr;
    logic [19:0]          op_wdata;
    logic                 op_store;
    logic                 op_load;
    logic [ADDR_BITS-1:0] idx;

    // While BUSY the held copy is the operation; upstream inputs are ignored.
    always_comb begin
        in_load  = (instruction[19:16] == OP_LOAD);
        mem_op   = valid_in & (writeEnable | in_load);
        busy     = (state_q == BUSY);
        op_instr = busy ? h_instr_q : instruction;
        op_addr  = busy ? h_addr_q  : address;
        op_wdata = busy ? h_wdata_q : writeData;
        op_store = busy ? h_store_q : writeEnable;
        op_load  = busy ? h_load_q  : (~writeEnable & in_load);
        idx      = op_addr[ADDR_BITS-1:0];
        stall    = 1'b0;
        complete = 1'b0;
        capture  = 1'b0;
        if (!reset) begin
            if (busy) begin
                stall    = (cnt_q != 4'd0);
                complete = (cnt_q == 4'd0);
            end else begin
                stall    = mem_op & HAS_WAIT;
                complete = valid_in & ~stall;
                capture  = stall;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            h_instr_q   <= 20'd0;
            h_addr_q    <= 20'd0;
            h_wdata_q   <= 20'd0;
            h_store_q   <= 1'b0;
            h_load_q    <= 1'b0;
            valid_q     <= 1'b0;
            instr_out_q <= 20'd0;
            result_q    <= 20'd0;
            is_load_q   <= 1'b0;
        end else begin
            valid_q <= complete;
            if (complete) begin
                instr_out_q <= op_instr;
                result_q    <= op_load ? mem[idx] : op_addr;
                is_load_q   <= op_load;
            end
            unique case (state_q)
                IDLE: begin
                    if (capture) begin
                        h_instr_q <= instruction;
                        h_addr_q  <= address;
                        h_wdata_q <= writeData;
                        h_store_q <= writeEnable;
                        h_load_q  <= ~writeEnable & in_load;
                        cnt_q     <= LAT_M1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // RAM is not reset; a store only lands on its completion edge.
    always_ff @(posedge clock) begin
        if (complete && op_store) begin
            mem[idx] <= op_wdata;
        end
    end

    assign valid_out       = valid_q;
    assign instruction_out = instr_out_q;
    assign result_out      = result_q;
    assign is_load_out     = is_load_q;

`ifdef DMEM_STATS_EN
    logic [15:0] ld_cnt_q;
    logic [15:0] st_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_cnt_q <= 16'd0;
            st_cnt_q <= 16'd0;
        end else if (complete) begin
            if (op_load && ld_cnt_q != 16'hFFFF) begin
                ld_cnt_q <= ld_cnt_q + 16'd1;
            end
            if (op_store && st_cnt_q != 16'hFFFF) begin
                st_cnt_q <= st_cnt_q + 16'd1;
            end
        end
    end

    assign load_count  = ld_cnt_q;
    assign store_count = st_cnt_q;
`endif

endmodule
